tick_bcd_counter: RTL and testbench

Downstream consumer of the divided-clock stage. Samples the divider's slow square wave in the fast `clk` domain and detects its rising edges as single-cycle ticks. Counts those ticks in a multi-digit BCD stopwatch with start, stop and clear control. Feeds a display / seven-segment driver stage.

---
 rtl/tick_bcd_counter_pkg.sv | 13 +
 rtl/bcd_digit.sv | 28 ++
 rtl/tick_bcd_counter.sv | 73 +++++++
 tb/tb_tick_bcd_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_bcd_counter_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
// FSM encodings and the BCD digit ceiling.
package tick_bcd_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register (0..9) with clear and carry chain.
// Ports: clk, rst, inc, clr -> digit[3:0], carry_out.
import tick_bcd_counter_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry_out
);

    assign carry_out = inc & (digit == BCD_NINE);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            // 9 rolls over; any illegal 10..15 also lands on 0
            if (digit >= BCD_NINE)
                digit <= 4'd0;
            else
                digit <= digit + 4'd1;
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// BCD stopwatch counting rising edges of a slow divided clock.
// Ports: clk, rst, slow_clk, start, stop, clear -> bcd, running, paused, wrap, tick.
import tick_bcd_counter_pkg::*;

module tick_bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slow_clk,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  paused,
    output logic                  wrap,
    output logic                  tick
);

    state_t        state;
    state_t        state_nx;
    logic          slow_q;
    logic          slow_rise;
    logic          inc;
    logic [DIGITS:0] carry;

    assign slow_rise = slow_clk & ~slow_q;
    assign inc       = (state == ST_RUN) & slow_rise & ~clear;
    assign carry[0]  = inc;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .inc       (carry[i]),
            .clr       (clear),
            .digit     (bcd[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    always_comb begin
        state_nx = state;
        if (clear)
            state_nx = ST_IDLE;
        else if (stop) begin
            if (state == ST_RUN)
                state_nx = ST_PAUSE;
        end else if (start && state != ST_RUN)
            state_nx = ST_RUN;
    end

    always_ff @(posedge clk) begin
        // slow_q follows slow_clk even in reset so a level
        // already high at release does not look like an edge
        slow_q <= slow_clk;
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            paused  <= 1'b0;
            wrap    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == ST_RUN);
            paused  <= (state_nx == ST_PAUSE);
            wrap    <= carry[DIGITS];
            tick    <= slow_rise;
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Scoreboard bench for tick_bcd_counter (4-digit and 2-digit instances).
// Expectations come from a cycle model pushed at drive time.
module tb_tick_bcd_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        slow_clk = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] bcd4;
    logic [7:0]  bcd2;
    logic        run4, pau4, wrap4, tick4;
    logic        run2, pau2, wrap2, tick2;

    always #5 clk = ~clk;

    tick_bcd_counter #(.DIGITS(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .bcd      (bcd4),
        .running  (run4),
        .paused   (pau4),
        .wrap     (wrap4),
        .tick     (tick4)
    );

    tick_bcd_counter #(.DIGITS(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .bcd      (bcd2),
        .running  (run2),
        .paused   (pau2),
        .wrap     (wrap2),
        .tick     (tick2)
    );

    typedef struct {
        logic [15:0] bcd4;
        logic [7:0]  bcd2;
        logic        running;
        logic        paused;
        logic        wrap4;
        logic        wrap2;
        logic        tick;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ticks_seen = 0;
    logic m_sq = 1'b0;
    int   m_cnt = 0;
    int   m_st = 0;
    int   ph = 0;
    bit   hold_hi = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(int v, int d);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step(bit s, bit p, bit c, bit r);
        bit   sl;
        bit   rise;
        bit   inc;
        exp_t e;
        sl = hold_hi ? 1'b1 : (ph >= 3);
        slow_clk = sl;
        start = s;
        stop = p;
        clear = c;
        rst = r;
        rise = sl & ~m_sq;
        if (r) begin
            m_st = 0;
            m_cnt = 0;
            e.tick = 1'b0;
            e.wrap4 = 1'b0;
            e.wrap2 = 1'b0;
        end else begin
            inc = (m_st == 1) && rise && !c;
            e.tick = rise;
            e.wrap4 = inc && (m_cnt == 9999);
            e.wrap2 = inc && (m_cnt % 100 == 99);
            if (c) begin
                m_st = 0;
                m_cnt = 0;
            end else begin
                if (inc) m_cnt = (m_cnt + 1) % 10000;
                if (p) begin
                    if (m_st == 1) m_st = 2;
                end else if (s && m_st != 1) begin
                    m_st = 1;
                end
            end
        end
        m_sq = sl;
        e.running = (m_st == 1);
        e.paused = (m_st == 2);
        e.bcd4 = 16'(to_bcd(m_cnt, 4));
        e.bcd2 = 8'(to_bcd(m_cnt % 100, 2));
        sb.push_back(e);
        ph = (ph + 1) % 6;
        @(negedge clk);
    endtask

    task automatic wait_edge();
        while (ph != 3) step(0, 0, 0, 0);
    endtask

    task automatic edges(int n);
        repeat (n) begin
            wait_edge();
            step(0, 0, 0, 0);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (tick4) ticks_seen++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_bcd4", 32'(bcd4), 32'(e.bcd4));
            check("sb_bcd2", 32'(bcd2), 32'(e.bcd2));
            check("sb_run4", 32'(run4), 32'(e.running));
            check("sb_pau4", 32'(pau4), 32'(e.paused));
            check("sb_run2", 32'(run2), 32'(e.running));
            check("sb_pau2", 32'(pau2), 32'(e.paused));
            check("sb_wrap4", 32'(wrap4), 32'(e.wrap4));
            check("sb_wrap2", 32'(wrap2), 32'(e.wrap2));
            check("sb_tick4", 32'(tick4), 32'(e.tick));
            check("sb_tick2", 32'(tick2), 32'(e.tick));
        end
    end

    initial begin
        int base;
        // slow_clk high through reset and afterwards: no tick
        hold_hi = 1'b1;
        repeat (3) step(0, 0, 0, 1);
        base = ticks_seen;
        repeat (10) step(0, 0, 0, 0);
        check("t1_ticks", 32'(ticks_seen - base), 32'd0);
        check("t1_bcd", 32'(bcd4), 32'h0);
        check("t1_run", 32'(run4), 32'd0);
        hold_hi = 1'b0;
        ph = 3;

        // divide-by-6 source, 10 edges
        base = ticks_seen;
        step(1, 0, 0, 0);
        edges(10);
        check("t2_bcd", 32'(bcd4), 32'h0010);
        check("t2_ticks", 32'(ticks_seen - base), 32'd10);

        // 2-digit wrap
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        edges(99);
        check("t3_bcd99", 32'(bcd2), 32'h99);
        edges(1);
        check("t3_bcd00", 32'(bcd2), 32'h00);
        check("t3_wrap", 32'(wrap2), 32'd1);
        check("t3_run", 32'(run2), 32'd1);
        check("t3_bcd4", 32'(bcd4), 32'h0100);
        step(0, 0, 0, 0);
        check("t3_wrap_off", 32'(wrap2), 32'd0);
        check("t3_run_hold", 32'(run2), 32'd1);

        // stop / start coincident with edges
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        edges(5);
        check("t4_bcd5", 32'(bcd4), 32'h0005);
        wait_edge();
        step(0, 1, 0, 0);
        check("t4_bcd6", 32'(bcd4), 32'h0006);
        check("t4_paused", 32'(pau4), 32'd1);
        edges(3);
        check("t4_hold6", 32'(bcd4), 32'h0006);
        wait_edge();
        step(1, 0, 0, 0);
        check("t4_start6", 32'(bcd4), 32'h0006);
        check("t4_run", 32'(run4), 32'd1);
        edges(1);
        check("t4_bcd7", 32'(bcd4), 32'h0007);

        // clear coincident with edge
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        edges(42);
        check("t5_bcd42", 32'(bcd4), 32'h0042);
        wait_edge();
        step(0, 0, 1, 0);
        check("t5_bcd0", 32'(bcd4), 32'h0);
        check("t5_run", 32'(run4), 32'd0);
        check("t5_paused", 32'(pau4), 32'd0);
        check("t5_tick", 32'(tick4), 32'd1);

        // reset with start and edge
        step(1, 0, 0, 0);
        edges(123);
        check("t6_bcd123", 32'(bcd4), 32'h0123);
        wait_edge();
        step(1, 0, 0, 1);
        check("t6_bcd", 32'(bcd4), 32'h0);
        check("t6_run", 32'(run4), 32'd0);
        check("t6_paused", 32'(pau4), 32'd0);
        check("t6_wrap", 32'(wrap4), 32'd0);
        check("t6_tick", 32'(tick4), 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
